freq_gate_ctrl: RTL and testbench

//   Measurement sequencer for the frequency meter datapath. Runs the gate window, feeds edge pulses to the
//   clk-domain 4-digit BCD counter, clears it, latches its value and selects the /1 or /10 range.

---
 rtl/freq_meter_pkg.sv | 17 +
 rtl/edge_sync.sv | 22 ++
 rtl/freq_gate_ctrl.sv | 123 ++++++++++++
 tb/tb_freq_gate_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter gate sequencer.
// Optional build macro used by the sequencer: AUTO_RANGE_EN.
package freq_meter_pkg;

  localparam int              BCD_W    = 16;
  localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;
  localparam int              PRESCALE = 10;
  localparam int              GATE_W   = 27;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LATCH  = 2'd3
  } meas_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the raw signal pin plus a registered rising-edge pulse.
// The pulse appears 3 clk after the pin edge; levels shorter than 2 clk may be missed.
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_out
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      edge_out <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], async_in};
      edge_out <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer for the frequency meter: clear, count, settle, latch, free-running.
// Define AUTO_RANGE_EN to replace range_sel with automatic /1 <-> /10 ranging.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_CLEAR  | 1 cycle: clear external counter, pick window range, drop ovf
//   ST_GATE   | GATE_CYCLES cycles: qualified edges become cnt_inc pulses
//   ST_SETTLE | SETTLE_CYC cycles: let the last in-flight increment land
//   ST_LATCH  | 1 cycle: capture count (or BCD_MAX on overflow) into result
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int               GATE_CYCLES = 100_000_000,
  parameter int               SETTLE_CYC  = 2,
  parameter logic [BCD_W-1:0] LO_THRESH   = 16'h0900
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             signal,
  input  logic             range_sel,
  input  logic [BCD_W-1:0] cnt_value,
  input  logic             cnt_full,
  output logic             cnt_inc,
  output logic             cnt_clr,
  output logic [BCD_W-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             range_now
);

  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  meas_state_t         state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [3:0]          presc;
  logic                ovf;
  logic                win_range;
  logic                next_range;
  logic                edge_p;

  edge_sync u_edge_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (signal),
    .edge_out (edge_p)
  );

`ifdef AUTO_RANGE_EN
  logic unused_range_sel;
  assign unused_range_sel = range_sel;

  // Step up after an overflowed /1 window, step down once a /10 reading is small.
  always_comb begin
    next_range = range_now;
    if (overflow && !range_now)
      next_range = 1'b1;
    else if (range_now && (result < LO_THRESH))
      next_range = 1'b0;
  end
`else
  assign next_range = range_sel;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CLEAR;
      gate_cnt     <= '0;
      settle_cnt   <= '0;
      presc        <= '0;
      ovf          <= 1'b0;
      win_range    <= 1'b0;
      cnt_inc      <= 1'b0;
      cnt_clr      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      range_now    <= 1'b0;
    end else begin
      cnt_inc      <= 1'b0;
      cnt_clr      <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt_clr    <= 1'b1;
          presc      <= '0;
          ovf        <= 1'b0;
          gate_cnt   <= '0;
          settle_cnt <= '0;
          win_range  <= next_range;
          state      <= ST_GATE;
        end
        ST_GATE: begin
          if (edge_p) begin
            if (win_range && (presc != 4'(PRESCALE - 1))) begin
              presc <= presc + 4'd1;
            end else begin
              presc <= '0;
              // Holding off the increment at full keeps the counter from wrapping.
              if (cnt_full) ovf <= 1'b1;
              else          cnt_inc <= 1'b1;
            end
          end
          if (gate_cnt == GATE_W'(GATE_CYCLES - 1)) state <= ST_SETTLE;
          else                                      gate_cnt <= gate_cnt + GATE_W'(1);
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) state <= ST_LATCH;
          else                                         settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
        ST_LATCH: begin
          result       <= ovf ? BCD_MAX : cnt_value;
          overflow     <= ovf;
          range_now    <= win_range;
          result_valid <= 1'b1;
          state        <= ST_CLEAR;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Randomized bench for freq_gate_ctrl with a behavioural BCD counter and a window-level reference model.
// Honors AUTO_RANGE_EN the same way as the design.
module tb_freq_gate_ctrl;

  localparam int GATE   = 100;
  localparam int SETTLE = 2;
  localparam int WIN    = GATE + SETTLE + 2;

  logic        clk = 1'b0;
  logic        reset_n, signal, range_sel, cnt_full, cnt_inc, cnt_clr;
  logic        result_valid, overflow, range_now, force_full;
  logic [15:0] cnt_value, result, bcd_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  freq_gate_ctrl #(.GATE_CYCLES(GATE), .SETTLE_CYC(SETTLE), .LO_THRESH(16'h0900)) dut (
    .clk(clk), .reset_n(reset_n), .signal(signal), .range_sel(range_sel),
    .cnt_value(cnt_value), .cnt_full(cnt_full), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr),
    .result(result), .result_valid(result_valid), .overflow(overflow), .range_now(range_now)
  );

  function automatic logic [15:0] bcd_inc(logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int d = 0; d < 4; d++) begin
      if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
      else begin
        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] r;
    int v;
    r = '0;
    v = n;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // External 4-digit BCD counter the sequencer drives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              bcd_cnt <= '0;
    else if (cnt_clr)                          bcd_cnt <= '0;
    else if (cnt_inc && bcd_cnt != 16'h9999)   bcd_cnt <= bcd_inc(bcd_cnt);
  end
  assign cnt_value = bcd_cnt;
  assign cnt_full  = force_full || (bcd_cnt == 16'h9999);

  task automatic check(string tag, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // stimulus settings
  int   per, hi, phase, force_win, force_ph;
  logic rs_base, rs_noise;
  // sampled-input history, indexed by clock edge number since reset release
  logic p_hist  [0:4095];
  logic rs_hist [0:4095];
  // reference model
  int          k, ecnt, mcnt, inc_full;
  logic        m_ovf, wrange, full_prev, m_ovf_prev, m_rng_prev;
  logic [15:0] m_res_prev;
  int          cap_k;
  logic [15:0] cap_res;
  logic        cap_ovf, cap_rng;

  function automatic logic get_p(int i);
    return (i < 1) ? 1'b0 : p_hist[i];
  endfunction

  task automatic drive_next();
    int kn, phn, wn;
    kn  = k + 1;
    phn = (kn - 1) % WIN;
    wn  = (kn - 1) / WIN;
    signal     = (((kn + phase) % per) < hi);
    range_sel  = rs_noise ? 1'($urandom_range(0, 1)) : rs_base;
    force_full = (wn == force_win) && (phn >= force_ph);
    p_hist[kn]  = signal;
    rs_hist[kn] = range_sel;
    full_prev   = force_full || (bcd_cnt == 16'h9999);
  endtask

  task automatic begin_segment();
    k = 0; ecnt = 0; mcnt = 0; m_ovf = 0; wrange = 0;
    m_ovf_prev = 0; m_rng_prev = 0; m_res_prev = '0; cap_k = 0;
    drive_next();
  endtask

  task automatic step();
    int          ph;
    logic        det, exp_inc;
    logic [15:0] exp_res;
    @(posedge clk);
    k++;
    #1;
    ph = (k - 1) % WIN;
    if (ph == 0) begin
      ecnt = 0; mcnt = 0; m_ovf = 0;
`ifdef AUTO_RANGE_EN
      if (m_ovf_prev && !m_rng_prev)                  wrange = 1'b1;
      else if (m_rng_prev && m_res_prev < 16'h0900)   wrange = 1'b0;
      else                                            wrange = m_rng_prev;
`else
      wrange = rs_hist[k];
`endif
    end
    // pin rise sampled at edge j is acted on at edge j+3
    det = get_p(k - 3) && !get_p(k - 4);
    exp_inc = 1'b0;
    if (ph >= 1 && ph <= GATE && det) begin
      ecnt++;
      if (!wrange || (ecnt % 10 == 0)) begin
        if (full_prev) m_ovf = 1'b1;
        else begin
          exp_inc = 1'b1;
          mcnt++;
        end
      end
    end
    check("cnt_clr", 16'(cnt_clr), 16'(ph == 0));
    check("cnt_inc", 16'(cnt_inc), 16'(exp_inc));
    check("result_valid", 16'(result_valid), 16'(ph == WIN - 1));
    if (ph == WIN - 1) begin
      exp_res = m_ovf ? 16'h9999 : to_bcd(mcnt);
      check("result", result, exp_res);
      check("overflow", 16'(overflow), 16'(m_ovf));
      check("range_now", 16'(range_now), 16'(wrange));
      m_res_prev = exp_res; m_ovf_prev = m_ovf; m_rng_prev = wrange;
    end
    if (result_valid) begin
      cap_k = k; cap_res = result; cap_ovf = overflow; cap_rng = range_now;
    end
    if (cnt_inc && full_prev) inc_full++;
    drive_next();
  endtask

  task automatic run_windows(int n);
    for (int i = 0; i < n * WIN; i++) step();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_result"}, result, 16'h0000);
    check({tag, "_valid"}, 16'(result_valid), 16'h0);
    check({tag, "_overflow"}, 16'(overflow), 16'h0);
    check({tag, "_range"}, 16'(range_now), 16'h0);
    check({tag, "_inc"}, 16'(cnt_inc), 16'h0);
    check({tag, "_clr"}, 16'(cnt_clr), 16'h0);
  endtask

  initial begin
    reset_n = 1'b0; signal = 1'b0; range_sel = 1'b0; force_full = 1'b0;
    per = 1; hi = 0; phase = 0; force_win = -1; force_ph = 50;
    rs_base = 1'b0; rs_noise = 1'b0; inc_full = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    begin_segment();

    // idle: no edges
    run_windows(1);
    check("t1_valid_cycle", 16'(cap_k), 16'd104);
    check("t1_result", cap_res, 16'h0000);
    check("t1_overflow", 16'(cap_ovf), 16'h0);

    // period 4, /1
    per = 4; hi = 2; phase = 0; rs_base = 1'b0;
    run_windows(2);
    check("t2_result", cap_res, 16'h0025);
    check("t2_range", 16'(cap_rng), 16'h0);

    // period 2, /10
    per = 2; hi = 1; rs_base = 1'b1;
    run_windows(2);
`ifndef AUTO_RANGE_EN
    check("t3_result", cap_res, 16'h0005);
    check("t3_range", 16'(cap_rng), 16'h1);
`endif

    // counter reports full halfway through the gate
    rs_base = 1'b0;
    force_win = k / WIN;
    inc_full = 0;
    run_windows(1);
    force_win = -1;
    check("t4_result", cap_res, 16'h9999);
    check("t4_overflow", 16'(cap_ovf), 16'h1);
    check("t4_inc_while_full", 16'(inc_full), 16'h0);

    // slow signal after the overflowed window
    per = 8; hi = 4;
    run_windows(1);
`ifdef AUTO_RANGE_EN
    check("t5_range_up", 16'(cap_rng), 16'h1);
`endif
    run_windows(1);
`ifdef AUTO_RANGE_EN
    check("t5_range_down", 16'(cap_rng), 16'h0);
`endif

    // random patterns, range_sel wandering mid-window
    rs_noise = 1'b1;
    for (int w = 0; w < 6; w++) begin
      per   = $urandom_range(2, 12);
      hi    = $urandom_range(1, per - 1);
      phase = $urandom_range(0, 11);
      run_windows(1);
    end
    rs_noise = 1'b0;

    // abort mid-gate
    for (int i = 0; i < 51; i++) step();
    #2;
    reset_n = 1'b0;
    signal  = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    per = 4; hi = 2; phase = 0; rs_base = 1'b0;
    begin_segment();
    run_windows(1);
    check("t6_valid_cycle", 16'(cap_k), 16'd104);
    check("t6_result", cap_res, 16'h0025);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
